ni_flit_receiver: RTL and testbench
===================================

// Module: ni_flit_receiver
// PURPOSE
//  Router-side receiver for the NI->NoC flit link; the far end of the NI transmit path.
//  Frames the 8-bit flit stream into packets, checks header and tail, and depacketizes each into {dest, 32-bit word}.
//  Buffers complete packets in a small FIFO and presents them to the router switch with a valid/ready handshake.
//  Wire format: HEADER {tag[5:0], dest[1:0]}, D0=data[7:0], D1=data[15:8], D2=data[23:16], D3=data[31:24], TAIL.
// PARAMETERS
//  FIFO_DEPTH  4          packet FIFO entries (power of 2, >=2)
//  HEADER_TAG  6'b101111  required header[7:2]
//  TAIL_FLIT   8'hFF      required tail flit value
//  CNT_W       8          width of saturating error counters
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst            in   1      asynchronous, active-high reset
//  flit_in        in   8      flit from NI
//  flit_in_valid  in   1      flit_in valid
//  noc_ready      out  1      receiver can accept a flit this cycle
//  pkt_dest       out  2      destination of FIFO head packet
//  pkt_data       out  32     payload of FIFO head packet
//  pkt_valid      out  1      FIFO non-empty
//  pkt_ready      in   1      switch consumes head packet when pkt_valid&&pkt_ready
//  hdr_err_cnt    out  CNT_W  flits discarded while hunting for a header
//  tail_err_cnt   out  CNT_W  packets dropped for a bad tail
// BEHAVIOUR
//  Flit accept = flit_in_valid && noc_ready. noc_ready = (state!=TAIL) || !fifo_full (combinational, current-cycle state).
//  FSM: HUNT -> D0 -> D1 -> D2 -> D3 -> TAIL -> HUNT. Advances only on flit accept.
//   HUNT: flit[7:2]==HEADER_TAG -> latch dest=flit[1:0], go D0; otherwise discard and increment hdr_err_cnt.
//   Dn: latch the byte into data[8n+7:8n]; values are unchecked, so 0xFF is plain data (see CONFIGURATION).
//   TAIL: flit==TAIL_FLIT -> push {dest,data} into FIFO; else drop the packet and increment tail_err_cnt. Go HUNT in both cases.
//  A header is not re-synced mid-packet: a header-tagged flit in a Dn state is data.
//  Latency: pkt_valid rises the cycle after tail accept when the FIFO was empty. Back-to-back packets run at 1 flit/cycle.
//  FIFO: push and pop in the same cycle are legal at any occupancy. A full FIFO blocks only at TAIL (noc_ready=0 there).
//  pkt_dest/pkt_data are driven from the FIFO head; they are don't-care when pkt_valid=0 and stable while pkt_valid && !pkt_ready.
//  Counters saturate at all-ones; no wrap.
//  Reset values: noc_ready=1, pkt_valid=0, pkt_dest=0, pkt_data=0, both counters 0, state HUNT, FIFO empty.
//  Reset mid-packet discards the partial packet and all FIFO contents.
// CONFIGURATION
//  `SHORT_PKT_EN defined: in states D1, D2 or D3 a flit == TAIL_FLIT ends the packet early.
//   Bytes not yet received are zero. The packet is pushed only if the FIFO is not full; noc_ready is also gated by full in D1..D3.
//   Next state is HUNT. An explicit TAIL state is not entered for that packet.
//  `SHORT_PKT_EN undefined: fixed 6-flit packets; 0xFF in D0..D3 is data.
// STRUCTURE
//  Package noc_flit_pkg holds:
//   - HEADER_TAG and TAIL_FLIT defaults
//   - FSM state encoding (HUNT, D0..D3, TAIL)
//   - the noc_pkt_t {dest[1:0], data[31:0]} 34-bit packing
//  Sub-module noc_sync_fifo (WIDTH=34, DEPTH=FIFO_DEPTH, async active-high rst, full/empty, simultaneous push/pop).
//  FSM, assembly register and error counters live in ni_flit_receiver.
// TESTING
//  1 Flits BD,78,56,34,12,FF with pkt_ready=1 -> pkt_valid one cycle after tail accept; dest=2'b01, data=32'h12345678.
//  2 Flits 00,3C,BC,11,22,33,44,FF -> hdr_err_cnt=2; one packet, dest=0, data=32'h44332211.
//  3 Flits BE,01,02,03,04,AA -> no pkt_valid; tail_err_cnt=1; next valid packet received normally.
//  4 pkt_ready=0, send 5 packets (FIFO_DEPTH=4) -> noc_ready=0 in TAIL of packet 5.
//    Raise pkt_ready -> packet 5 accepted; 5 packets emerge in order.
//  5 rst pulse after BF,AA,BB -> pkt_valid=0, counters 0.
//    Then BF,01,02,03,04,FF -> dest=3, data=32'h04030201.
//  6 `SHORT_PKT_EN: BC,11,22,FF -> data=32'h00002211, dest=0.
//    Without the macro the same flits followed by 33,FF -> data=32'h33FF2211.

Source files
------------

// File: rtl/noc_flit_pkg.sv
// Shared types and defaults for the NI->NoC flit receive path.
package noc_flit_pkg;

  localparam logic [5:0] HEADER_TAG_DEF = 6'b101111;
  localparam logic [7:0] TAIL_FLIT_DEF  = 8'hFF;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_D0,
    ST_D1,
    ST_D2,
    ST_D3,
    ST_TAIL
  } rx_state_t;

  typedef struct packed {
    logic [1:0]  dest;
    logic [31:0] data;
  } noc_pkt_t;

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with full/empty flags; push and pop may coincide at any occupancy.
module noc_sync_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still take a push.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ni_flit_receiver.sv
// Frames the NI flit stream into {dest, data} packets and queues them for the switch.
// Optional SHORT_PKT_EN: a tail flit in D1..D3 ends the packet early with zero-filled bytes.
module ni_flit_receiver
  import noc_flit_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [5:0]  HEADER_TAG = HEADER_TAG_DEF,
  parameter logic [7:0]  TAIL_FLIT  = TAIL_FLIT_DEF,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       flit_in,
  input  logic             flit_in_valid,
  output logic             noc_ready,
  output logic [1:0]       pkt_dest,
  output logic [31:0]      pkt_data,
  output logic             pkt_valid,
  input  logic             pkt_ready,
  output logic [CNT_W-1:0] hdr_err_cnt,
  output logic [CNT_W-1:0] tail_err_cnt
);

  rx_state_t   state;
  logic [1:0]  dest_q;
  logic [31:0] data_q;
  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic        push;
  logic        tail_match;
  noc_pkt_t    push_pkt;
  noc_pkt_t    head_pkt;

  assign tail_match = (flit_in == TAIL_FLIT);
  assign accept     = flit_in_valid && noc_ready;
  assign push_pkt   = '{dest: dest_q, data: data_q};

  always_comb begin
    noc_ready = 1'b1;
    if (state == ST_TAIL) noc_ready = !fifo_full;
`ifdef SHORT_PKT_EN
    if (state inside {ST_D1, ST_D2, ST_D3}) noc_ready = !fifo_full;
`endif
  end

  always_comb begin
    push = 1'b0;
    if (accept && tail_match) begin
      if (state == ST_TAIL) push = 1'b1;
`ifdef SHORT_PKT_EN
      if (state inside {ST_D1, ST_D2, ST_D3}) push = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_HUNT;
      dest_q       <= '0;
      data_q       <= '0;
      hdr_err_cnt  <= '0;
      tail_err_cnt <= '0;
    end else if (accept) begin
      case (state)
        ST_HUNT: begin
          if (flit_in[7:2] == HEADER_TAG) begin
            dest_q <= flit_in[1:0];
            data_q <= '0;
            state  <= ST_D0;
          end else if (hdr_err_cnt != '1) begin
            hdr_err_cnt <= hdr_err_cnt + 1'b1;
          end
        end
        ST_D0: begin
          data_q[7:0] <= flit_in;
          state       <= ST_D1;
        end
        ST_D1: begin
          data_q[15:8] <= flit_in;
          state        <= ST_D2;
`ifdef SHORT_PKT_EN
          if (tail_match) begin
            data_q[15:8] <= data_q[15:8];
            state        <= ST_HUNT;
          end
`endif
        end
        ST_D2: begin
          data_q[23:16] <= flit_in;
          state         <= ST_D3;
`ifdef SHORT_PKT_EN
          if (tail_match) begin
            data_q[23:16] <= data_q[23:16];
            state         <= ST_HUNT;
          end
`endif
        end
        ST_D3: begin
          data_q[31:24] <= flit_in;
          state         <= ST_TAIL;
`ifdef SHORT_PKT_EN
          if (tail_match) begin
            data_q[31:24] <= data_q[31:24];
            state         <= ST_HUNT;
          end
`endif
        end
        ST_TAIL: begin
          if (!tail_match && (tail_err_cnt != '1)) tail_err_cnt <= tail_err_cnt + 1'b1;
          state <= ST_HUNT;
        end
        default: state <= ST_HUNT;
      endcase
    end
  end

  noc_sync_fifo #(
    .WIDTH ($bits(noc_pkt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_pkt),
    .pop       (pkt_ready),
    .head_data (head_pkt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pkt_valid = !fifo_empty;
  assign pkt_dest  = head_pkt.dest;
  assign pkt_data  = head_pkt.data;

endmodule

// File: tb/tb_ni_flit_receiver.sv
// Randomized and directed bench for ni_flit_receiver against a byte-queue packet model.
module tb_ni_flit_receiver;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 8;
  localparam logic [5:0]  TAG   = 6'b101111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    flit_in = '0;
  logic          flit_in_valid = 1'b0;
  logic          noc_ready;
  logic [1:0]    pkt_dest;
  logic [31:0]   pkt_data;
  logic          pkt_valid;
  logic          pkt_ready = 1'b0;
  logic [CW-1:0] hdr_err_cnt;
  logic [CW-1:0] tail_err_cnt;

  int checks = 0;
  int errors = 0;

  // Model: bytes of the packet in progress (header first), queue of expected packets, error counts.
  logic [7:0]  mbuf [$];
  logic [33:0] mq   [$];
  int          m_hdr  = 0;
  int          m_tail = 0;

  ni_flit_receiver #(
    .FIFO_DEPTH (DEPTH),
    .HEADER_TAG (TAG),
    .TAIL_FLIT  (8'hFF),
    .CNT_W      (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flit_in       (flit_in),
    .flit_in_valid (flit_in_valid),
    .noc_ready     (noc_ready),
    .pkt_dest      (pkt_dest),
    .pkt_data      (pkt_data),
    .pkt_valid     (pkt_valid),
    .pkt_ready     (pkt_ready),
    .hdr_err_cnt   (hdr_err_cnt),
    .tail_err_cnt  (tail_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int n);
    return (n >= (1 << CW) - 1) ? (1 << CW) - 1 : n + 1;
  endfunction

  function automatic logic model_ready();
    int  pos;
    logic blocked;
    pos = mbuf.size();
    blocked = (pos == 5);
`ifdef SHORT_PKT_EN
    blocked = (pos >= 2 && pos <= 5);
`endif
    return !blocked || (mq.size() < DEPTH);
  endfunction

  function automatic void model_emit(input int nbytes);
    logic [31:0] w;
    w = '0;
    for (int k = 1; k <= nbytes; k++) w[8*(k-1) +: 8] = mbuf[k];
    mq.push_back({mbuf[0][1:0], w});
  endfunction

  function automatic void model_flit(input logic [7:0] f);
    if (mbuf.size() == 0) begin
      if (f[7:2] == TAG) mbuf.push_back(f);
      else m_hdr = sat(m_hdr);
      return;
    end
    mbuf.push_back(f);
    if (mbuf.size() == 6) begin
      if (f == 8'hFF) model_emit(4);
      else m_tail = sat(m_tail);
      mbuf.delete();
    end
`ifdef SHORT_PKT_EN
    else if (mbuf.size() >= 3 && f == 8'hFF) begin
      model_emit(mbuf.size() - 2);
      mbuf.delete();
    end
`endif
  endfunction

  function automatic void model_reset();
    mbuf.delete();
    mq.delete();
    m_hdr  = 0;
    m_tail = 0;
  endfunction

  // One clock: drive at negedge, compare settled outputs, then advance the model.
  task automatic cycle(input logic v, input logic [7:0] f, input logic r, output logic acc);
    logic exp_rdy;
    @(negedge clk);
    flit_in       = f;
    flit_in_valid = v;
    pkt_ready     = r;
    #1;
    exp_rdy = model_ready();
    check_val("noc_ready", noc_ready, exp_rdy);
    check_val("pkt_valid", pkt_valid, mq.size() > 0);
    if (mq.size() > 0) check_val("pkt_head", {pkt_dest, pkt_data}, mq[0]);
    check_val("hdr_err_cnt", hdr_err_cnt, m_hdr);
    check_val("tail_err_cnt", tail_err_cnt, m_tail);
    acc = v && exp_rdy;
    if (r && mq.size() > 0) void'(mq.pop_front());
    if (acc) model_flit(f);
  endtask

  task automatic send_flit(input logic [7:0] f, input logic r);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      cycle(1'b1, f, r, acc);
      n++;
    end
    if (!acc) check_val("accept_timeout", 0, 1);
  endtask

  task automatic send_seq(input logic [7:0] s [], input logic r);
    foreach (s[i]) send_flit(s[i], r);
  endtask

  task automatic idle(input int n, input logic r);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, r, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    flit_in_valid = 1'b0;
    pkt_ready = 1'b0;
    model_reset();
    #1;
    check_val("rst_noc_ready", noc_ready, 1);
    check_val("rst_pkt_valid", pkt_valid, 0);
    check_val("rst_pkt_dest", pkt_dest, 0);
    check_val("rst_pkt_data", pkt_data, 0);
    check_val("rst_hdr_cnt", hdr_err_cnt, 0);
    check_val("rst_tail_cnt", tail_err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic acc;
    logic [7:0] f;

    do_reset();

    // Basic packet
    send_seq('{8'hBD, 8'h78, 8'h56, 8'h34, 8'h12, 8'hFF}, 1'b0);
    idle(1, 1'b0);
    check_val("t1_valid", pkt_valid, 1);
    check_val("t1_pkt", {pkt_dest, pkt_data}, {2'b01, 32'h12345678});
    idle(2, 1'b1);

    // Header hunting
    do_reset();
    send_seq('{8'h00, 8'h3C, 8'hBC, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF}, 1'b0);
    idle(1, 1'b0);
    check_val("t2_hdr_cnt", hdr_err_cnt, 2);
    check_val("t2_pkt", {pkt_dest, pkt_data}, {2'b00, 32'h44332211});
    idle(2, 1'b1);

    // Bad tail, then a good packet
    do_reset();
    send_seq('{8'hBE, 8'h01, 8'h02, 8'h03, 8'h04, 8'hAA}, 1'b1);
    idle(1, 1'b1);
    check_val("t3_valid", pkt_valid, 0);
    check_val("t3_tail_cnt", tail_err_cnt, 1);
    send_seq('{8'hBE, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF}, 1'b0);
    idle(1, 1'b0);
    check_val("t3_pkt", {pkt_dest, pkt_data}, {2'b10, 32'h04030201});
    idle(2, 1'b1);

    // FIFO full backpressure at the fifth tail
    do_reset();
    for (int p = 0; p < 4; p++)
      send_seq('{8'hBC | 8'(p), 8'(p), 8'hA1, 8'hA2, 8'hA3, 8'hFF}, 1'b0);
    send_seq('{8'hBF, 8'h55, 8'h66, 8'h77, 8'h88}, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hFF, 1'b0, acc);
    check_val("t4_full_block", noc_ready, 0);
    send_flit(8'hFF, 1'b1);
    idle(6, 1'b1);
    check_val("t4_drained", pkt_valid, 0);

    // Reset in the middle of a packet
    do_reset();
    send_seq('{8'hBF, 8'hAA, 8'hBB}, 1'b0);
    do_reset();
    send_seq('{8'hBF, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF}, 1'b0);
    idle(1, 1'b0);
    check_val("t5_pkt", {pkt_dest, pkt_data}, {2'b11, 32'h04030201});
    idle(2, 1'b1);

    // Early tail handling
    do_reset();
    send_seq('{8'hBC, 8'h11, 8'h22, 8'hFF}, 1'b0);
`ifdef SHORT_PKT_EN
    idle(1, 1'b0);
    check_val("t6_short_pkt", {pkt_dest, pkt_data}, {2'b00, 32'h00002211});
`else
    send_seq('{8'h33, 8'hFF}, 1'b0);
    idle(1, 1'b0);
    check_val("t6_long_pkt", {pkt_dest, pkt_data}, {2'b00, 32'h33FF2211});
`endif
    idle(2, 1'b1);

    // Header error counter saturation
    do_reset();
    for (int i = 0; i < 260; i++) send_flit(8'h00, 1'b1);
    idle(1, 1'b1);
    check_val("sat_hdr_cnt", hdr_err_cnt, 8'hFF);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(9))
        0, 1, 2, 3: f = {TAG, 2'($urandom_range(3))};
        4, 5:       f = 8'hFF;
        default:    f = 8'($urandom_range(255));
      endcase
      cycle($urandom_range(9) < 8, f, (i % 200 < 40) ? 1'b0 : 1'($urandom_range(1)), acc);
    end
    idle(10, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
